cpu7_tlb_arb: RTL and testbench

- Single-outstanding arbiter/sequencer in front of tlb_wrapper, shared by three requesters:
  - instruction-fetch translation (i)
  - data translation (d)
  - TLB maintenance ops from the CSR/exec path (m: tlbsrch/tlbrd/tlbwr/tlbfill/invtlb)
- Serialises them onto one lookup port, routes results back to the owner, and enforces maintenance-op ordering.
- Instantiated in cpu7 between the ifu/lsu/csr request sources and tlb_wrapper.

---
 rtl/cpu7_tlb_arb_pkg.sv | 26 ++
 rtl/cpu7_tlb_arb_pick.sv | 52 +++++
 rtl/cpu7_tlb_arb.sv | 201 ++++++++++++++++++++
 tb/tb_cpu7_tlb_arb.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_tlb_arb_pkg.sv
// cpu7_tlb_arb_pkg
//   Shared encodings for the TLB request arbiter: request source codes
//   (also driven on tlb_src), arbiter state encodings, grant vector bit
//   positions and the "no exception" exccode value.
package cpu7_tlb_arb_pkg;

    localparam logic [1:0] TLB_ARB_SRC_I = 2'd0;
    localparam logic [1:0] TLB_ARB_SRC_D = 2'd1;
    localparam logic [1:0] TLB_ARB_SRC_M = 2'd2;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_I = 0;
    localparam int GNT_D = 1;
    localparam int GNT_M = 2;

    localparam logic [5:0] TLB_EXCCODE_NONE = 6'd0;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_BUSY_I = 3'd1,
        ARB_BUSY_D = 3'd2,
        ARB_BUSY_M = 3'd3,
        ARB_DROP   = 3'd4
    } tlb_arb_state_e;

endpackage

// File: rtl/cpu7_tlb_arb_pick.sv
// cpu7_tlb_arb_pick
//   Pure combinational priority selector for the TLB arbiter.
//   Priority is m > d > i, except that i overtakes d once the starvation
//   counter has reached STARVE_MAX. i and d are ineligible during flush.
// Ports:
//   i_req, d_req, m_req  in   raw requests
//   flush                in   pipeline flush (masks i and d)
//   starve_cnt           in   consecutive d grants seen while i waited
//   grant                out  one-hot grant {m, d, i}, zero when nothing eligible
//   src                  out  source code of the granted requester
module cpu7_tlb_arb_pick
    import cpu7_tlb_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic             m_req,
    input  logic             flush,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic [2:0]       grant,
    output logic [1:0]       src
);

    logic i_ok;
    logic d_ok;
    logic force_i;

    assign i_ok    = i_req & ~flush;
    assign d_ok    = d_req & ~flush;
    assign force_i = i_ok && (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        grant = 3'b000;
        src   = TLB_ARB_SRC_I;
        if (m_req) begin
            grant[GNT_M] = 1'b1;
            src          = TLB_ARB_SRC_M;
        end else if (force_i) begin
            grant[GNT_I] = 1'b1;
            src          = TLB_ARB_SRC_I;
        end else if (d_ok) begin
            grant[GNT_D] = 1'b1;
            src          = TLB_ARB_SRC_D;
        end else if (i_ok) begin
            grant[GNT_I] = 1'b1;
            src          = TLB_ARB_SRC_I;
        end
    end

endmodule

// File: rtl/cpu7_tlb_arb.sv
// cpu7_tlb_arb
//   Single-outstanding arbiter in front of tlb_wrapper. Serialises
//   instruction (i), data (d) and maintenance (m) translation requests onto
//   one TLB port, routes the registered result back to the owner as a
//   one-cycle x_finish pulse, and discards results of flushed i/d requests.
// Optional feature: define CPU7_TLB_ARB_PERF_EN to add perf counters
//   (perf_i_cnt, perf_d_cnt, perf_m_cnt, perf_stall_cnt) and perf_clr.
// Ports:
//   clk, reset                   clock, async active-high reset
//   flush                        cancels i/d requests; never affects m
//   i_req/i_vaddr/i_recv/i_finish          inst translation handshake
//   d_req/d_wr/d_vaddr/d_recv/d_finish     data translation handshake
//   m_req/m_op/m_vaddr/m_recv/m_finish     TLB maintenance handshake
//   res_hit/res_paddr/res_exccode          shared result registers
//   tlb_valid/src/vaddr/wr/op, tlb_ready   request to tlb_wrapper
//   tlb_done/hit/paddr/exccode             response from tlb_wrapper
module cpu7_tlb_arb
    import cpu7_tlb_arb_pkg::*;
#(
    parameter int GRLEN      = 32,
    parameter int PABITS     = 32,
    parameter int OPW        = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              i_req,
    input  logic [GRLEN-1:0]  i_vaddr,
    output logic              i_recv,
    output logic              i_finish,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [GRLEN-1:0]  d_vaddr,
    output logic              d_recv,
    output logic              d_finish,
    input  logic              m_req,
    input  logic [OPW-1:0]    m_op,
    input  logic [GRLEN-1:0]  m_vaddr,
    output logic              m_recv,
    output logic              m_finish,
    output logic              res_hit,
    output logic [PABITS-1:0] res_paddr,
    output logic [5:0]        res_exccode,
    output logic              tlb_valid,
    output logic [1:0]        tlb_src,
    output logic [GRLEN-1:0]  tlb_vaddr,
    output logic              tlb_wr,
    output logic [OPW-1:0]    tlb_op,
    input  logic              tlb_ready,
    input  logic              tlb_done,
    input  logic              tlb_hit,
    input  logic [PABITS-1:0] tlb_paddr,
    input  logic [5:0]        tlb_exccode
`ifdef CPU7_TLB_ARB_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [31:0]       perf_i_cnt,
    output logic [31:0]       perf_d_cnt,
    output logic [31:0]       perf_m_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    tlb_arb_state_e   state;
    tlb_arb_state_e   state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             m_pend;
    logic [2:0]       grant;
    logic [1:0]       pick_src;
    logic             busy_id;
    logic             capture;

    // m_pend is only ever set while BUSY_M, so this masking mirrors the
    // occupancy rule and keeps i/d out until the maintenance op completes.
    cpu7_tlb_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .i_req      (i_req & ~m_pend),
        .d_req      (d_req & ~m_pend),
        .m_req      (m_req),
        .flush      (flush),
        .starve_cnt (starve_cnt),
        .grant      (grant),
        .src        (pick_src)
    );

    assign busy_id = (state == ARB_BUSY_I) || (state == ARB_BUSY_D);
    // A result is kept unless its i/d owner was flushed in the same cycle.
    assign capture = tlb_done && ((state == ARB_BUSY_M) || (busy_id && !flush));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (tlb_ready) begin
                    if (grant[GNT_M])      state_nxt = ARB_BUSY_M;
                    else if (grant[GNT_D]) state_nxt = ARB_BUSY_D;
                    else if (grant[GNT_I]) state_nxt = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (tlb_done)   state_nxt = ARB_IDLE;
                else if (flush) state_nxt = ARB_DROP;
            end
            ARB_BUSY_M: if (tlb_done) state_nxt = ARB_IDLE;
            ARB_DROP:   if (tlb_done) state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        tlb_valid = 1'b0;
        i_recv    = 1'b0;
        d_recv    = 1'b0;
        m_recv    = 1'b0;
        if (state == ARB_IDLE) begin
            tlb_valid = |grant;
            i_recv    = grant[GNT_I] & tlb_ready;
            d_recv    = grant[GNT_D] & tlb_ready;
            m_recv    = grant[GNT_M] & tlb_ready;
        end
    end

    assign tlb_src   = pick_src;
    assign tlb_vaddr = grant[GNT_M] ? m_vaddr :
                       grant[GNT_D] ? d_vaddr :
                       grant[GNT_I] ? i_vaddr : '0;
    assign tlb_wr    = grant[GNT_D] & d_wr;
    assign tlb_op    = grant[GNT_M] ? m_op : '0;

    // Counts d grants taken while i waits; cleared whenever i is served or
    // has gone away so only a continuous wait can force an i grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == ARB_IDLE) begin
            if (i_recv || !i_req)
                starve_cnt <= '0;
            else if (d_recv && (starve_cnt != CNT_W'(STARVE_MAX)))
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   m_pend <= 1'b0;
        else if (m_recv)                             m_pend <= 1'b1;
        else if ((state == ARB_BUSY_M) && tlb_done)  m_pend <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_finish    <= 1'b0;
            d_finish    <= 1'b0;
            m_finish    <= 1'b0;
            res_hit     <= 1'b0;
            res_paddr   <= '0;
            res_exccode <= TLB_EXCCODE_NONE;
        end else begin
            i_finish <= capture && (state == ARB_BUSY_I);
            d_finish <= capture && (state == ARB_BUSY_D);
            m_finish <= capture && (state == ARB_BUSY_M);
            if (capture) begin
                res_hit     <= tlb_hit;
                res_paddr   <= tlb_paddr;
                res_exccode <= tlb_exccode;
            end
        end
    end

`ifdef CPU7_TLB_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_i_cnt     <= 32'd0;
            perf_d_cnt     <= 32'd0;
            perf_m_cnt     <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else if (perf_clr) begin
            perf_i_cnt     <= 32'd0;
            perf_d_cnt     <= 32'd0;
            perf_m_cnt     <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (i_finish) perf_i_cnt <= perf_i_cnt + 32'd1;
            if (d_finish) perf_d_cnt <= perf_d_cnt + 32'd1;
            if (m_finish) perf_m_cnt <= perf_m_cnt + 32'd1;
            if ((state == ARB_IDLE) && tlb_valid && !tlb_ready)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu7_tlb_arb.sv
// Testbench for cpu7_tlb_arb. Directed scenarios followed by a randomized
// run, all checked every cycle against a transaction-level model of the
// arbiter (owner of the single outstanding slot, starvation count, result).
module tb_cpu7_tlb_arb;

    localparam int GRLEN      = 32;
    localparam int PABITS     = 32;
    localparam int OPW        = 5;
    localparam int STARVE_MAX = 4;

    localparam int O_NONE = -1;
    localparam int O_I    = 0;
    localparam int O_D    = 1;
    localparam int O_M    = 2;
    localparam int O_DROP = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              i_req = 1'b0;
    logic [GRLEN-1:0]  i_vaddr = '0;
    logic              i_recv, i_finish;
    logic              d_req = 1'b0;
    logic              d_wr = 1'b0;
    logic [GRLEN-1:0]  d_vaddr = '0;
    logic              d_recv, d_finish;
    logic              m_req = 1'b0;
    logic [OPW-1:0]    m_op = '0;
    logic [GRLEN-1:0]  m_vaddr = '0;
    logic              m_recv, m_finish;
    logic              res_hit;
    logic [PABITS-1:0] res_paddr;
    logic [5:0]        res_exccode;
    logic              tlb_valid;
    logic [1:0]        tlb_src;
    logic [GRLEN-1:0]  tlb_vaddr;
    logic              tlb_wr;
    logic [OPW-1:0]    tlb_op;
    logic              tlb_ready = 1'b1;
    logic              tlb_done = 1'b0;
    logic              tlb_hit = 1'b0;
    logic [PABITS-1:0] tlb_paddr = '0;
    logic [5:0]        tlb_exccode = '0;
`ifdef CPU7_TLB_ARB_PERF_EN
    logic              perf_clr = 1'b0;
    logic [31:0]       perf_i_cnt, perf_d_cnt, perf_m_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    cpu7_tlb_arb #(
        .GRLEN(GRLEN), .PABITS(PABITS), .OPW(OPW), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_recv(i_recv), .i_finish(i_finish),
        .d_req(d_req), .d_wr(d_wr), .d_vaddr(d_vaddr), .d_recv(d_recv), .d_finish(d_finish),
        .m_req(m_req), .m_op(m_op), .m_vaddr(m_vaddr), .m_recv(m_recv), .m_finish(m_finish),
        .res_hit(res_hit), .res_paddr(res_paddr), .res_exccode(res_exccode),
        .tlb_valid(tlb_valid), .tlb_src(tlb_src), .tlb_vaddr(tlb_vaddr),
        .tlb_wr(tlb_wr), .tlb_op(tlb_op), .tlb_ready(tlb_ready),
        .tlb_done(tlb_done), .tlb_hit(tlb_hit), .tlb_paddr(tlb_paddr),
        .tlb_exccode(tlb_exccode)
`ifdef CPU7_TLB_ARB_PERF_EN
        ,
        .perf_clr(perf_clr), .perf_i_cnt(perf_i_cnt), .perf_d_cnt(perf_d_cnt),
        .perf_m_cnt(perf_m_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                owner;
    int                starve;
    logic              e_hit;
    logic [PABITS-1:0] e_paddr;
    logic [5:0]        e_exc;
    logic [2:0]        e_fin;

    // Values observed in the last tick (before its clock edge)
    logic [2:0]        smp_recv;
    logic [2:0]        smp_fin;
    logic [1:0]        smp_src;
    logic              smp_valid;
    logic [PABITS-1:0] smp_res_paddr;
    logic [5:0]        smp_res_exc;
    logic              smp_hit;
    int                src_log[$];

    // Scripted TLB responder
    bit                resp_busy = 1'b0;
    int                resp_wait = 0;
    bit                hold_d = 1'b0;
    logic [PABITS-1:0] keep_paddr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner   = O_NONE;
        starve  = 0;
        e_hit   = 1'b0;
        e_paddr = '0;
        e_exc   = '0;
        e_fin   = 3'b000;
    endtask

    // Who the arbiter should offer to the TLB this cycle
    function automatic int model_pick();
        if (owner != O_NONE) return O_NONE;
        if (m_req)           return O_M;
        if (flush)           return O_NONE;
        if (i_req && starve == STARVE_MAX) return O_I;
        if (d_req)           return O_D;
        if (i_req)           return O_I;
        return O_NONE;
    endfunction

    // Check the cycle at its midpoint, then cross the clock edge and advance
    // the model with the inputs that were present at that edge.
    task automatic tick();
        int  p;
        int  prev;
        bit  acc;
        #4;
        p = model_pick();
        smp_valid     = tlb_valid;
        smp_recv      = {m_recv, d_recv, i_recv};
        smp_fin       = {m_finish, d_finish, i_finish};
        smp_src       = tlb_src;
        smp_res_paddr = res_paddr;
        smp_res_exc   = res_exccode;
        smp_hit       = res_hit;
        chk("tlb_valid", 64'(tlb_valid), 64'(p != O_NONE));
        chk("recv", 64'(smp_recv), (p != O_NONE && tlb_ready) ? (64'd1 << p) : 64'd0);
        if (p != O_NONE) begin
            chk("tlb_src", 64'(tlb_src), 64'(p));
            chk("tlb_vaddr", 64'(tlb_vaddr), 64'(p == O_M ? m_vaddr : (p == O_D ? d_vaddr : i_vaddr)));
            chk("tlb_wr", 64'(tlb_wr), 64'(p == O_D && d_wr));
            chk("tlb_op", 64'(tlb_op), 64'(p == O_M ? m_op : 5'd0));
        end
        chk("finish", 64'(smp_fin), 64'(e_fin));
        chk("res_hit", 64'(res_hit), 64'(e_hit));
        chk("res_paddr", 64'(res_paddr), 64'(e_paddr));
        chk("res_exccode", 64'(res_exccode), 64'(e_exc));
        @(posedge clk);
        prev  = owner;
        acc   = (p != O_NONE) && tlb_ready;
        e_fin = 3'b000;
        if (prev == O_NONE) begin
            if (!i_req || (acc && p == O_I)) starve = 0;
            else if (acc && p == O_D && starve < STARVE_MAX) starve++;
            if (acc) owner = p;
        end else if (prev == O_M || ((prev == O_I || prev == O_D) && !flush)) begin
            if (tlb_done) begin
                e_fin   = 3'(1 << prev);
                e_hit   = tlb_hit;
                e_paddr = tlb_paddr;
                e_exc   = tlb_exccode;
                owner   = O_NONE;
            end
        end else if (prev == O_I || prev == O_D) begin
            owner = tlb_done ? O_NONE : O_DROP;
        end else if (tlb_done) begin
            owner = O_NONE;
        end
        #1;
    endtask

    // Cycles with an automatic TLB responder; rnd adds random traffic.
    task automatic run(input int n, input bit rnd);
        for (int c = 0; c < n; c++) begin
            tlb_done = 1'b0;
            if (resp_busy && resp_wait == 0) begin
                tlb_done  = 1'b1;
                resp_busy = 1'b0;
            end else if (resp_busy) begin
                resp_wait--;
            end else if (rnd && $urandom_range(0, 9) == 0) begin
                tlb_done = 1'b1;
            end
            tlb_hit     = 1'($urandom);
            tlb_paddr   = $urandom;
            tlb_exccode = 6'($urandom);
            if (rnd) begin
                tlb_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 11) == 0);
                if (!i_req && $urandom_range(0, 2) == 0) begin
                    i_req = 1'b1; i_vaddr = $urandom;
                end
                if (!d_req && $urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_vaddr = $urandom; d_wr = 1'($urandom);
                end
                if (!m_req && $urandom_range(0, 7) == 0) begin
                    m_req = 1'b1; m_vaddr = $urandom; m_op = 5'($urandom);
                end
            end
            tick();
            if (smp_recv != 3'b000) begin
                resp_busy = 1'b1;
                resp_wait = rnd ? int'($urandom_range(0, 3)) : 1;
                src_log.push_back(int'(smp_src));
            end
            if (smp_recv[0]) i_req = 1'b0;
            if (smp_recv[1] && !hold_d) d_req = 1'b0;
            if (smp_recv[2]) m_req = 1'b0;
        end
        tlb_done = 1'b0;
    endtask

    initial begin
        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #4;
        chk("rst_valid", 64'(tlb_valid), 64'd0);
        chk("rst_recv", 64'({m_recv, d_recv, i_recv}), 64'd0);
        chk("rst_finish", 64'({m_finish, d_finish, i_finish}), 64'd0);
        chk("rst_res", 64'({res_hit, res_exccode, res_paddr}), 64'd0);
        reset = 1'b0;

        // Single i translation: recv at cycle 0, done at 3, finish at 4
        i_req = 1'b1; i_vaddr = 32'h1c00_0000;
        tick();
        chk("t1_i_recv", 64'(smp_recv), 64'b001);
        i_req = 1'b0;
        tick();
        tick();
        tlb_done = 1'b1; tlb_hit = 1'b1; tlb_paddr = 32'h1c00_0000; tlb_exccode = 6'd0;
        tick();
        tlb_done = 1'b0; tlb_paddr = 32'h5555_5555; tlb_exccode = 6'h3f;
        tick();
        chk("t1_i_finish", 64'(smp_fin), 64'b001);
        chk("t1_res_paddr", 64'(smp_res_paddr), 64'h1c00_0000);
        chk("t1_res_exccode", 64'(smp_res_exc), 64'd0);
        chk("t1_res_hit", 64'(smp_hit), 64'd1);

        // All three at once: m, then d, then i
        src_log.delete();
        i_req = 1'b1; i_vaddr = 32'h0000_1000;
        d_req = 1'b1; d_vaddr = 32'h0000_2000; d_wr = 1'b1;
        m_req = 1'b1; m_vaddr = 32'h0000_3000; m_op = 5'h06;
        run(15, 1'b0);
        chk("t2_grants", 64'(src_log.size()), 64'd3);
        if (src_log.size() >= 3) begin
            chk("t2_src0", 64'(src_log[0]), 64'd2);
            chk("t2_src1", 64'(src_log[1]), 64'd1);
            chk("t2_src2", 64'(src_log[2]), 64'd0);
        end

        // Starvation: continuous d with waiting i
        src_log.delete();
        hold_d = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_vaddr = 32'h0000_4000;
        i_req = 1'b1; i_vaddr = 32'h0000_5000;
        run(40, 1'b0);
        chk("t3_grants_ge6", 64'(src_log.size() >= 6), 64'd1);
        if (src_log.size() >= 6) begin
            chk("t3_d0", 64'(src_log[0]), 64'd1);
            chk("t3_d3", 64'(src_log[3]), 64'd1);
            chk("t3_i4", 64'(src_log[4]), 64'd0);
            chk("t3_d5", 64'(src_log[5]), 64'd1);
        end
        hold_d = 1'b0; d_req = 1'b0;
        run(6, 1'b0);

        // i flushed the cycle before done: result dropped
        keep_paddr = e_paddr;
        i_req = 1'b1; i_vaddr = 32'h1000_0040;
        tick();
        chk("t4_i_recv", 64'(smp_recv), 64'b001);
        i_req = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; d_req = 1'b1; d_vaddr = 32'h1000_0080;
        tlb_done = 1'b1; tlb_paddr = 32'hdead_0000;
        tick();
        chk("t4_no_recv_drop", 64'(smp_recv), 64'd0);
        tlb_done = 1'b0;
        tick();
        chk("t4_no_finish", 64'(smp_fin), 64'd0);
        chk("t4_res_kept", 64'(smp_res_paddr), 64'(keep_paddr));
        chk("t4_d_recv", 64'(smp_recv), 64'b010);
        d_req = 1'b0; resp_busy = 1'b1; resp_wait = 1;
        run(4, 1'b0);

        // invtlb keeps running through a flush; d waits for flush low
        m_req = 1'b1; m_op = 5'h13; m_vaddr = 32'h0000_0a5a;
        tick();
        chk("t5_m_recv", 64'(smp_recv), 64'b100);
        m_req = 1'b0; flush = 1'b1; d_req = 1'b1; d_vaddr = 32'h2000_0000;
        tick();
        chk("t5_d_blocked", 64'(smp_recv), 64'd0);
        tick();
        tlb_done = 1'b1; tlb_paddr = 32'h0000_0abc; tlb_hit = 1'b0; tlb_exccode = 6'h0b;
        tick();
        tlb_done = 1'b0;
        tick();
        chk("t5_m_finish", 64'(smp_fin), 64'b100);
        chk("t5_res_paddr", 64'(smp_res_paddr), 64'h0abc);
        chk("t5_d_flushed", 64'(smp_recv), 64'd0);
        flush = 1'b0;
        tick();
        chk("t5_d_recv", 64'(smp_recv), 64'b010);
        d_req = 1'b0; resp_busy = 1'b1; resp_wait = 1;
        run(4, 1'b0);

        // Back-pressure: ready low for 5 cycles with d pending
`ifdef CPU7_TLB_ARB_PERF_EN
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
`endif
        d_req = 1'b1; d_vaddr = 32'h3000_0000; tlb_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_valid_held", 64'(smp_valid), 64'd1);
            chk("t6_no_recv", 64'(smp_recv), 64'd0);
        end
        tlb_ready = 1'b1;
        tick();
        chk("t6_d_recv", 64'(smp_recv), 64'b010);
`ifdef CPU7_TLB_ARB_PERF_EN
        chk("t6_perf_stall", 64'(perf_stall_cnt), 64'd5);
`endif
        d_req = 1'b0; resp_busy = 1'b1; resp_wait = 1;
        run(4, 1'b0);

        // Async reset in BUSY_M returns to IDLE and clears results
        m_req = 1'b1; m_op = 5'h01;
        tick();
        m_req = 1'b0;
        tick();
        d_req = 1'b1; d_vaddr = 32'h4000_0000;
        #2 reset = 1'b1;
        #1;
        chk("t7_res_rst", 64'({res_hit, res_exccode, res_paddr}), 64'd0);
        chk("t7_fin_rst", 64'({m_finish, d_finish, i_finish}), 64'd0);
        reset = 1'b0;
        model_reset();
        tick();
        chk("t7_d_recv", 64'(smp_recv), 64'b010);
        d_req = 1'b0; resp_busy = 1'b1; resp_wait = 1;
        run(4, 1'b0);

        // Randomized traffic
        run(3000, 1'b1);
        i_req = 1'b0; d_req = 1'b0; m_req = 1'b0; flush = 1'b0; tlb_ready = 1'b1;
        run(10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
